// File: rtl/key_conditioner.sv
// Four-lane pushbutton conditioner: 2-flop synchronizer, per-lane debounce counter, registered level/press/release.
// Optional auto-repeat of PRESS while held is built when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int COUNT_BITS      = 25
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] KEY,
   output logic [3:0] LEVEL,
   output logic [3:0] PRESS,
   output logic [3:0] RELEASE
);

   localparam logic [COUNT_BITS-1:0] DEB_TC  = COUNT_BITS'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

   if ((DEBOUNCE_CYCLES < 1) || ((DEBOUNCE_CYCLES >>> COUNT_BITS) != 0) ||
       (HOLD_CYCLES < 1)     || ((HOLD_CYCLES >>> COUNT_BITS) != 0) ||
       (REPEAT_CYCLES < 1)   || ((REPEAT_CYCLES >>> COUNT_BITS) != 0)) begin : g_bad_params
      $error("key_conditioner: cycle parameter out of range for COUNT_BITS");
   end

   logic [3:0]            sync1;
   logic [3:0]            sync2;
   logic [3:0]            pressed_s;
   logic [3:0]            accept;
   logic [COUNT_BITS-1:0] deb_cnt [4];

   assign pressed_s = ~sync2;

   // A lane accepts on the edge where its counter already shows DEBOUNCE_CYCLES-1 mismatching cycles.
   always_comb begin
      accept = '0;
      for (int i = 0; i < 4; i++) begin
         accept[i] = (pressed_s[i] != LEVEL[i]) && (deb_cnt[i] == DEB_TC);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1   <= '1;
         sync2   <= '1;
         LEVEL   <= '0;
         RELEASE <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1   <= KEY;
         sync2   <= sync1;
         LEVEL   <= LEVEL ^ accept;
         RELEASE <= accept & LEVEL;
         for (int i = 0; i < 4; i++) begin
            if ((pressed_s[i] == LEVEL[i]) || accept[i]) begin
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
            end
         end
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [COUNT_BITS-1:0] HOLD_TC = COUNT_BITS'(HOLD_CYCLES - 1);
   localparam logic [COUNT_BITS-1:0] REP_TC  = COUNT_BITS'(REPEAT_CYCLES - 1);

   logic [COUNT_BITS-1:0] hold_cnt [4];
   logic [3:0]            repeating;
   logic [3:0]            rep_fire;

   // The hold counter restarts on every emitted pulse; the first interval is HOLD, later ones REPEAT.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 4; i++) begin
         rep_fire[i] = LEVEL[i] && !accept[i] &&
                       (hold_cnt[i] == (repeating[i] ? REP_TC : HOLD_TC));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         PRESS     <= '0;
         repeating <= '0;
         for (int i = 0; i < 4; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         PRESS <= (accept & ~LEVEL) | rep_fire;
         for (int i = 0; i < 4; i++) begin
            if (!LEVEL[i] || accept[i] || rep_fire[i]) begin
               hold_cnt[i] <= '0;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
            end
            if (!LEVEL[i] || accept[i]) begin
               repeating[i] <= 1'b0;
            end else if (rep_fire[i]) begin
               repeating[i] <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         PRESS <= '0;
      end else begin
         PRESS <= accept & ~LEVEL;
      end
   end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner; reference model judges each edge from the sampled key history.
module tb_key_conditioner;

   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 3;
   localparam int CB   = 5;
   localparam int HMAX = 4096;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       CLK;
   logic       RST;
   logic [3:0] KEY;
   logic [3:0] LEVEL;
   logic [3:0] PRESS;
   logic [3:0] RELEASE;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .COUNT_BITS     (CB)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .KEY    (KEY),
      .LEVEL  (LEVEL),
      .PRESS  (PRESS),
      .RELEASE(RELEASE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model: history of inputs per edge, plus the expected outputs after the latest edge.
   logic       rst_h  [HMAX];
   logic [3:0] samp_h [HMAX];
   int         t = 0;
   logic [3:0] m_level = '0;
   logic [3:0] m_press = '0;
   logic [3:0] m_rel   = '0;
   int         pstart [4] = '{-1, -1, -1, -1};

   // Debounced-path view of the key at edge idx: two synchronizer stages behind the raw sample.
   function automatic logic [3:0] ps_at(int idx);
      if (idx < 2) return 4'h0;
      if (rst_h[idx-1]) return 4'h0;
      return samp_h[idx-2];
   endfunction

   function automatic void model_step(logic [3:0] k, logic r);
      logic [3:0] p;
      bit         stable;
      int         idx;
      int         age;
      rst_h[t]  = r;
      samp_h[t] = r ? 4'h0 : ~k;
      m_press   = '0;
      m_rel     = '0;
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            m_level[i] = 1'b0;
            pstart[i]  = -1;
         end else begin
            stable = 1'b1;
            for (int j = 0; j < DEB; j++) begin
               idx = t - j;
               if (idx < 2) stable = 1'b0;
               else begin
                  p = ps_at(idx);
                  if (rst_h[idx] || (p[i] == m_level[i])) stable = 1'b0;
               end
            end
            if (stable) begin
               m_level[i] = ~m_level[i];
               if (m_level[i]) begin
                  m_press[i] = 1'b1;
                  pstart[i]  = t;
               end else begin
                  m_rel[i]  = 1'b1;
                  pstart[i] = -1;
               end
            end else if (AR && m_level[i] && (pstart[i] >= 0)) begin
               age = t - pstart[i];
               if ((age >= HOLD) && (((age - HOLD) % REP) == 0)) m_press[i] = 1'b1;
            end
         end
      end
      t++;
   endfunction

   task automatic tick();
      logic [3:0] k;
      logic       r;
      k = KEY;
      r = RST;
      @(posedge CLK);
      #1;
      model_step(k, r);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      KEY = 4'hF;
      repeat (5) begin
         tick();
         checks++;
         if ({LEVEL, PRESS, RELEASE} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold got L=%h P=%h R=%h exp all 0", LEVEL, PRESS, RELEASE);
         end
      end
      RST = 1'b0;
      repeat (20) begin
         tick();
         checks++;
         if ({LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel} || LEVEL !== 4'h0) begin
            failures++;
            $display("FAIL reset_idle got L=%h P=%h R=%h exp all 0", LEVEL, PRESS, RELEASE);
         end
      end
   endtask

   task automatic test_press_release();
      logic [3:0] el, ep, er;
      KEY = 4'hE;
      for (int n = 1; n <= 9; n++) begin
         tick();
         el = (n >= 6) ? 4'h1 : 4'h0;
         ep = (n == 6) ? 4'h1 : 4'h0;
         checks++;
         if ({LEVEL, PRESS, RELEASE} !== {el, ep, 4'h0} ||
             {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
            failures++;
            $display("FAIL press0 edge%0d got L=%h P=%h R=%h exp L=%h P=%h R=0", n, LEVEL, PRESS, RELEASE, el, ep);
         end
      end
      KEY = 4'hF;
      for (int n = 1; n <= 8; n++) begin
         tick();
         el = (n >= 6) ? 4'h0 : 4'h1;
         er = (n == 6) ? 4'h1 : 4'h0;
         checks++;
         if ({LEVEL, PRESS, RELEASE} !== {el, 4'h0, er} ||
             {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
            failures++;
            $display("FAIL release0 edge%0d got L=%h P=%h R=%h exp L=%h P=0 R=%h", n, LEVEL, PRESS, RELEASE, el, er);
         end
      end
   endtask

   task automatic test_glitch();
      repeat (5) begin
         KEY = 4'hD;
         repeat (3) begin
            tick();
            checks++;
            if (LEVEL[1] !== 1'b0 || PRESS[1] !== 1'b0 || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
               failures++;
               $display("FAIL glitch1 got L=%h P=%h R=%h exp L=%h P=%h R=%h", LEVEL, PRESS, RELEASE, m_level, m_press, m_rel);
            end
         end
         KEY = 4'hF;
         repeat (3) begin
            tick();
            checks++;
            if (LEVEL[1] !== 1'b0 || PRESS[1] !== 1'b0 || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
               failures++;
               $display("FAIL glitch1_gap got L=%h P=%h R=%h exp L=%h P=%h R=%h", LEVEL, PRESS, RELEASE, m_level, m_press, m_rel);
            end
         end
      end
   endtask

   task automatic test_simultaneous_and_reset();
      KEY = 4'h3;
      for (int n = 1; n <= 6; n++) begin
         tick();
         checks++;
         if (PRESS !== ((n == 6) ? 4'hC : 4'h0) || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
            failures++;
            $display("FAIL simul23 edge%0d got P=%h L=%h exp P=%h", n, PRESS, LEVEL, (n == 6) ? 4'hC : 4'h0);
         end
      end
      KEY = 4'hF;
      repeat (8) tick();
      checks++;
      if (LEVEL !== 4'h0 || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
         failures++;
         $display("FAIL simul23_release got L=%h exp 0", LEVEL);
      end
      KEY = 4'h7;
      repeat (4) tick();
      RST = 1'b1;
      tick();
      checks++;
      if ({LEVEL, PRESS, RELEASE} !== 12'h000) begin
         failures++;
         $display("FAIL rst_mid_debounce got L=%h P=%h R=%h exp all 0", LEVEL, PRESS, RELEASE);
      end
      RST = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         tick();
         checks++;
         if (PRESS !== ((n == 6) ? 4'h8 : 4'h0) || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
            failures++;
            $display("FAIL press3_after_rst edge%0d got P=%h exp %h", n, PRESS, (n == 6) ? 4'h8 : 4'h0);
         end
      end
      KEY = 4'hF;
      repeat (8) tick();
   endtask

   task automatic test_autorepeat();
      int  pulses;
      int  exp_pulses;
      logic ep;
      pulses     = 0;
      exp_pulses = 0;
      KEY = 4'hE;
      for (int n = 1; n <= 45; n++) begin
         if (n == 31) KEY = 4'hF;
         tick();
         ep = (n == 6) || (AR && (n >= 16) && (n <= 35) && (((n - 16) % REP) == 0));
         if (PRESS[0]) pulses++;
         if (ep) exp_pulses++;
         checks++;
         if (PRESS[0] !== ep || {LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel}) begin
            failures++;
            $display("FAIL autorepeat edge%0d got P0=%b exp %b model P=%h", n, PRESS[0], ep, m_press);
         end
      end
      checks++;
      if (pulses != exp_pulses || LEVEL[0] !== 1'b0) begin
         failures++;
         $display("FAIL autorepeat_count got %0d pulses L0=%b exp %0d pulses L0=0", pulses, LEVEL[0], exp_pulses);
      end
   endtask

   task automatic test_random();
      int run [4];
      logic [3:0] k;
      for (int i = 0; i < 4; i++) run[i] = 1;
      k = 4'hF;
      repeat (900) begin
         for (int i = 0; i < 4; i++) begin
            run[i]--;
            if (run[i] <= 0) begin
               k[i]   = ~k[i];
               run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(1, 7));
            end
         end
         KEY = k;
         RST = ($urandom_range(0, 149) == 0);
         tick();
         checks++;
         if ({LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_rel} || (PRESS & RELEASE) !== 4'h0) begin
            failures++;
            $display("FAIL random t=%0d got L=%h P=%h R=%h exp L=%h P=%h R=%h", t, LEVEL, PRESS, RELEASE, m_level, m_press, m_rel);
         end
      end
      RST = 1'b0;
      KEY = 4'hF;
   endtask

   initial begin
      RST = 1'b1;
      KEY = 4'hF;
      test_reset();
      test_press_release();
      test_glitch();
      test_simultaneous_and_reset();
      test_autorepeat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
